// File: rtl/mdu_sched_if.sv
// Request/grant and unit-side bus between the issue pipes, mdu_sched and the mult/div units.
// slave = scheduler view, master = pipeline/unit side.
interface mdu_sched_if;
  logic        req_a_valid;
  logic        req_b_valid;
  logic [2:0]  req_a_op;
  logic [2:0]  req_b_op;
  logic [31:0] req_a_src_a;
  logic [31:0] req_a_src_b;
  logic [31:0] req_b_src_a;
  logic [31:0] req_b_src_b;
  logic        grant_a;
  logic        grant_b;
  logic [1:0]  mult_op;
  logic [1:0]  div_op;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        mult_done;
  logic        div_done;
  logic [63:0] mult_result;
  logic [63:0] div_result;

  modport slave (
    input  req_a_valid, req_b_valid, req_a_op, req_b_op,
    input  req_a_src_a, req_a_src_b, req_b_src_a, req_b_src_b,
    output grant_a, grant_b,
    output mult_op, div_op, unit_a, unit_b,
    input  mult_done, div_done, mult_result, div_result
  );

  modport master (
    output req_a_valid, req_b_valid, req_a_op, req_b_op,
    output req_a_src_a, req_a_src_b, req_b_src_a, req_b_src_b,
    input  grant_a, grant_b,
    input  mult_op, div_op, unit_a, unit_b,
    output mult_done, div_done, mult_result, div_result
  );
endinterface

// File: rtl/mdu_sched.sv
// Arbiter/sequencer for the shared multiply/divide unit: grant, launch pulse, wait for done rise, HI/LO commit.
// Optional MDU_SCHED_RR_EN: round-robin between alpha and beta instead of fixed alpha priority.
//
// state  | meaning
// IDLE   | no op outstanding, requests may be granted
// LAUNCH | one-cycle mult_op/div_op start pulse
// WAIT   | waiting for a rising edge on the selected unit's done
// COMMIT | hilo_wen strobe (unless killed by flush)
module mdu_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        hilo_accessed,
  mdu_sched_if.slave  bus,
  output logic        hilo_wen,
  output logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMMIT} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic        kill_q;
  logic        done_prev_q;
  logic [1:0]  mult_op_q;
  logic [1:0]  div_op_q;
  logic        wen_q;
  logic [63:0] wdata_q;

  logic        pick_b;
  logic        can_grant;
  logic        grant_a;
  logic        grant_b;
  logic        done_sel;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

`ifdef MDU_SCHED_RR_EN
  logic prio_q;

  // prio_q set means beta wins the next simultaneous request
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (grant_a || grant_b) begin
      prio_q <= grant_a;
    end
  end

  assign pick_b = prio_q;
`else
  assign pick_b = 1'b0;
`endif

  always_comb begin
    can_grant = (state_q == IDLE) && !flush_i && !rst;
    grant_a   = can_grant && bus.req_a_valid && (!bus.req_b_valid || !pick_b);
    grant_b   = can_grant && bus.req_b_valid && (!bus.req_a_valid || pick_b);
    sel_op    = grant_b ? bus.req_b_op    : bus.req_a_op;
    sel_a     = grant_b ? bus.req_b_src_a : bus.req_a_src_a;
    sel_b     = grant_b ? bus.req_b_src_b : bus.req_a_src_b;
    done_sel  = op_q[2] ? bus.div_done : bus.mult_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      kill_q      <= 1'b0;
      done_prev_q <= 1'b0;
      mult_op_q   <= 2'b00;
      div_op_q    <= 2'b00;
      wen_q       <= 1'b0;
      wdata_q     <= 64'd0;
    end else begin
      mult_op_q <= 2'b00;
      div_op_q  <= 2'b00;
      wen_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_a || grant_b) begin
            op_q   <= sel_op;
            opa_q  <= sel_a;
            opb_q  <= sel_b;
            kill_q <= 1'b0;
            if (sel_op[2]) div_op_q  <= sel_op[1:0];
            else           mult_op_q <= sel_op[1:0];
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          // a done still high from before the launch must not count as the rising edge
          done_prev_q <= 1'b1;
          kill_q      <= kill_q || flush_i;
          state_q     <= WAIT;
        end
        WAIT: begin
          done_prev_q <= done_sel;
          kill_q      <= kill_q || flush_i;
          if (done_sel && !done_prev_q) begin
            wdata_q <= op_q[2] ? bus.div_result : bus.mult_result;
            wen_q   <= !(kill_q || flush_i);
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          kill_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_a = grant_a;
  assign bus.grant_b = grant_b;
  assign bus.mult_op = mult_op_q;
  assign bus.div_op  = div_op_q;
  assign bus.unit_a  = opa_q;
  assign bus.unit_b  = opb_q;
  assign hilo_wen    = wen_q;
  assign hilo_wdata  = wdata_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    stall_o = 1'b0;
    if (!flush_i) begin
      stall_o = (busy && hilo_accessed) || (bus.req_a_valid && !grant_a) ||
                (bus.req_b_valid && !grant_b);
    end
  end

endmodule
